// File: rtl/tri_geom_seq.sv
// Triangle geometry sequencer: squared side lengths and twice the signed area
// of triangle ABC. One shared 9x9 signed multiplier, one product per CALC step.
module tri_geom_seq (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [7:0]  x1,
    input  logic signed [7:0]  y1,
    input  logic signed [7:0]  x2,
    input  logic signed [7:0]  y2,
    input  logic signed [7:0]  x3,
    input  logic signed [7:0]  y3,
    output logic               busy,
    output logic               done,
    output logic [16:0]        ab2,
    output logic [16:0]        bc2,
    output logic [16:0]        ca2,
    output logic signed [17:0] det,
    output logic               collinear,
    output logic               ccw
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic               w_accept;
    logic [2:0]         r_step;

    logic signed [8:0]  r_dAbX;
    logic signed [8:0]  r_dAbY;
    logic signed [8:0]  r_dBcX;
    logic signed [8:0]  r_dBcY;
    logic signed [8:0]  r_dCaX;
    logic signed [8:0]  r_dCaY;

    logic [16:0]        r_accAb;
    logic [16:0]        r_accBc;
    logic [16:0]        r_accCa;
    logic signed [17:0] r_accDet;

    logic signed [8:0]  w_mulA;
    logic signed [8:0]  w_mulB;
    logic signed [17:0] w_product;
    logic signed [17:0] w_detFinal;

    // State register; reset always lands in IDLE, ahead of any start request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic plus busy/done decode; start is only looked at in IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_stateNext = ST_CALC;
                end
            end
            ST_CALC: begin
                busy = 1'b1;
                if (r_step == 3'd7) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Operand select for the single shared multiplier, one product per step.
    always_comb begin
        w_mulA = 9'sd0;
        w_mulB = 9'sd0;
        case (r_step)
            3'd0: begin w_mulA = r_dAbX; w_mulB = r_dAbX; end
            3'd1: begin w_mulA = r_dAbY; w_mulB = r_dAbY; end
            3'd2: begin w_mulA = r_dBcX; w_mulB = r_dBcX; end
            3'd3: begin w_mulA = r_dBcY; w_mulB = r_dBcY; end
            3'd4: begin w_mulA = r_dCaX; w_mulB = r_dCaX; end
            3'd5: begin w_mulA = r_dCaY; w_mulB = r_dCaY; end
            3'd6: begin w_mulA = r_dAbY; w_mulB = r_dCaX; end
            3'd7: begin w_mulA = r_dAbX; w_mulB = r_dCaY; end
            default: begin w_mulA = 9'sd0; w_mulB = 9'sd0; end
        endcase
    end

    // The shared product and the final determinant formed on the last step.
    always_comb begin
        w_product  = w_mulA * w_mulB;
        w_detFinal = r_accDet - w_product;
    end

    // Datapath: capture differences on accept, accumulate in CALC, publish on step 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step    <= 3'd0;
            r_dAbX    <= 9'sd0;
            r_dAbY    <= 9'sd0;
            r_dBcX    <= 9'sd0;
            r_dBcY    <= 9'sd0;
            r_dCaX    <= 9'sd0;
            r_dCaY    <= 9'sd0;
            r_accAb   <= 17'd0;
            r_accBc   <= 17'd0;
            r_accCa   <= 17'd0;
            r_accDet  <= 18'sd0;
            ab2       <= 17'd0;
            bc2       <= 17'd0;
            ca2       <= 17'd0;
            det       <= 18'sd0;
            collinear <= 1'b0;
            ccw       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_step <= 3'd0;
                r_dAbX <= {x2[7], x2} - {x1[7], x1};
                r_dAbY <= {y2[7], y2} - {y1[7], y1};
                r_dBcX <= {x3[7], x3} - {x2[7], x2};
                r_dBcY <= {y3[7], y3} - {y2[7], y2};
                r_dCaX <= {x1[7], x1} - {x3[7], x3};
                r_dCaY <= {y1[7], y1} - {y3[7], y3};
            end
            if (r_state == ST_CALC) begin
                r_step <= r_step + 3'd1;
                case (r_step)
                    3'd0: r_accAb  <= w_product[16:0];
                    3'd1: r_accAb  <= r_accAb + w_product[16:0];
                    3'd2: r_accBc  <= w_product[16:0];
                    3'd3: r_accBc  <= r_accBc + w_product[16:0];
                    3'd4: r_accCa  <= w_product[16:0];
                    3'd5: r_accCa  <= r_accCa + w_product[16:0];
                    3'd6: r_accDet <= w_product;
                    3'd7: begin
                        r_accDet  <= w_detFinal;
                        ab2       <= r_accAb;
                        bc2       <= r_accBc;
                        ca2       <= r_accCa;
                        det       <= w_detFinal;
                        collinear <= (w_detFinal == 18'sd0);
                        ccw       <= (w_detFinal > 18'sd0);
                    end
                    default: begin
                        r_accDet <= r_accDet;
                    end
                endcase
            end
        end
    end

endmodule
